// File: rtl/vc_test_source_rand.sv
// ---------------------------------------------------------------------------
// vc_test_source_rand
//
// Stimulus source for block-level benches. Streams the messages preloaded in
// memory m over a val/rdy interface, optionally inserting a pseudo-random
// number of idle cycles before each message, and raises done once every
// message has been accepted downstream.
//
// The stream ends at the first entry whose value is all-X (the end-of-stream
// sentinel) or after ENTRIES messages, whichever comes first. m is written by
// the bench (hierarchical write) before reset is released; reset never
// clears it.
//
// Ports:
//   clk       in   1           clock, all state changes on the rising edge
//   reset     in   1           synchronous, active-low reset
//   bits      out  BIT_WIDTH   message payload (registered)
//   val       out  1           payload valid (registered)
//   rdy       in   1           downstream ready
//   done      out  1           every message has been accepted (registered)
//   num_sent  out  INDEX_BITS  number of accepted messages
// ---------------------------------------------------------------------------
module vc_test_source_rand #(
    parameter int unsigned BIT_WIDTH    = 1,
    parameter int unsigned RANDOM_DELAY = 0,
    parameter int unsigned ENTRIES      = 1024,
    parameter int unsigned INDEX_BITS   = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [BIT_WIDTH-1:0]  bits,
    output logic                  val,
    input  logic                  rdy,
    output logic                  done,
    output logic [INDEX_BITS-1:0] num_sent
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_SEND  = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // One extra bit lets the index reach ENTRIES even when ENTRIES == 2**INDEX_BITS.
    localparam int unsigned IW     = INDEX_BITS + 1;
    localparam int unsigned AW     = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned RD_DIV = (RANDOM_DELAY > 0) ? RANDOM_DELAY : 1;
    localparam logic [IW-1:0] LAST = IW'(ENTRIES);
    localparam logic [IW-1:0] ONE  = IW'(1);
    localparam logic [31:0]   SEED = 32'hACE1_2468;
    localparam logic [31:0]   TAPS = 32'h8020_0003;

    // Message memory, loaded from outside before reset is released.
    logic [BIT_WIDTH-1:0] m [ENTRIES-1:0];

    state_t          r_state;
    logic [IW-1:0]   r_index;
    logic [IW-1:0]   r_num_sent;
    logic [31:0]     r_rand_delay;
    logic [31:0]     r_lfsr;

    logic            w_cur_in;
    logic [AW-1:0]   w_cur_addr;
    logic [BIT_WIDTH-1:0] w_cur_data;
    logic            w_cur_end;
    logic [IW-1:0]   w_index_nxt;
    logic            w_nxt_in;
    logic [AW-1:0]   w_nxt_addr;
    logic [BIT_WIDTH-1:0] w_nxt_data;
    logic            w_nxt_ok;
    logic [31:0]     w_reload;
    logic [31:0]     w_lfsr_nxt;

    function automatic logic is_sentinel(input logic [BIT_WIDTH-1:0] v);
        return (v === {BIT_WIDTH{1'bx}});
    endfunction

    // Addresses are forced to 0 when out of range so m is never read past
    // its last entry; the in-range flag masks the data in that case.
    assign w_cur_in    = (r_index < LAST);
    assign w_cur_addr  = w_cur_in ? AW'(r_index) : '0;
    assign w_cur_data  = m[w_cur_addr];
    assign w_cur_end   = !w_cur_in || is_sentinel(w_cur_data);

    assign w_index_nxt = r_index + ONE;
    assign w_nxt_in    = (w_index_nxt < LAST);
    assign w_nxt_addr  = w_nxt_in ? AW'(w_index_nxt) : '0;
    assign w_nxt_data  = m[w_nxt_addr];

    // Galois LFSR stands in for $random so the delay source is synthesizable.
    // With RANDOM_DELAY == 0 the divisor is 1 and the reload is always 0.
    assign w_lfsr_nxt  = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : '0);
    assign w_reload    = r_lfsr % RD_DIV;

    // Back-to-back only when no delay was drawn and the next entry is a real message.
    assign w_nxt_ok    = (w_reload == '0) && w_nxt_in && !is_sentinel(w_nxt_data);

    // Counter is one bit wider than the port; pin at all-ones if it cannot be shown.
    assign num_sent    = r_num_sent[IW-1] ? '1 : r_num_sent[INDEX_BITS-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= S_FETCH;
            r_index      <= '0;
            r_num_sent   <= '0;
            r_rand_delay <= '0;
            r_lfsr       <= SEED;
            bits         <= '0;
            val          <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_cur_end) begin
                        r_state <= S_DONE;
                        done    <= 1'b1;
                        val     <= 1'b0;
                    end else if (r_rand_delay != '0) begin
                        r_rand_delay <= r_rand_delay - 32'd1;
                    end else begin
                        bits    <= w_cur_data;
                        val     <= 1'b1;
                        r_state <= S_SEND;
                    end
                end

                S_SEND: begin
                    // val is always high here, so rdy alone marks a transfer.
                    if (rdy) begin
                        r_index      <= w_index_nxt;
                        if (r_num_sent != LAST) begin
                            r_num_sent <= r_num_sent + ONE;
                        end
                        r_rand_delay <= w_reload;
                        r_lfsr       <= w_lfsr_nxt;
                        if (w_nxt_ok) begin
                            bits <= w_nxt_data;
                        end else begin
                            val     <= 1'b0;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_DONE: begin
                    val  <= 1'b0;
                    done <= 1'b1;
                end

                default: begin
                    r_state <= S_FETCH;
                    val     <= 1'b0;
                end
            endcase
        end
    end

endmodule
